// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO.
// Queued bytes are sent back-to-back. The next start bit follows the previous
// stop bit with no idle clock between them.
module uart_tx_fifo #(
    parameter int BAUD_DIV = 2604,  // clocks per serial bit, 4..4095
    parameter int DEPTH    = 4      // FIFO entries, power of 2, 2..16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       tx_done
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(DEPTH);
    localparam logic [11:0]      BAUD_RELOAD = 12'(BAUD_DIV - 1);
    localparam logic [3:0]       STOP_BIT    = 4'd9;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // FIFO storage is a small register file.
    // The head is read combinationally so a byte written at one edge can be
    // loaded at the very next edge.
    logic [7:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic [0:0]  state_reg;
    logic [0:0]  state_next;
    logic [8:0]  shift_reg;
    logic [8:0]  shift_next;
    logic [11:0] baud_cnt_reg;
    logic [11:0] baud_cnt_next;
    logic [3:0]  bit_cnt_reg;
    logic [3:0]  bit_cnt_next;
    logic        tx_reg;
    logic        tx_next;

    logic push;
    logic load;
    logic frame_end;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);

    // A push while full is dropped, even if a pop happens in the same cycle.
    assign push = trmt & ~full;

    // frame_end marks the last clock of a stop bit.
    assign frame_end = (state_reg == SEND) && (baud_cnt_reg == '0) && (bit_cnt_reg == STOP_BIT);

    assign TX      = tx_reg;
    assign busy    = (state_reg == SEND);
    assign tx_done = frame_end;

    // Write the incoming byte into the FIFO slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= tx_data;
        end
    end

    // FIFO occupancy. A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, load})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Update the FIFO pointers and count. The pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (load) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Transmit sequencing.
    // A load pops the FIFO head into {data, start bit}. Each shift feeds in 1s,
    // so the ninth shift leaves the stop bit at bit 0.
    // tx_next always holds the next value of bit 0, so TX comes straight from a flop.
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        tx_next       = tx_reg;
        load          = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (!empty) begin
                    load = 1'b1;
                end
            end
            SEND: begin
                if (baud_cnt_reg != '0) begin
                    baud_cnt_next = baud_cnt_reg - 12'd1;
                end else if (bit_cnt_reg != STOP_BIT) begin
                    shift_next    = {1'b1, shift_reg[8:1]};
                    tx_next       = shift_reg[1];
                    bit_cnt_next  = bit_cnt_reg + 4'd1;
                    baud_cnt_next = BAUD_RELOAD;
                end else if (!empty) begin
                    // The stop bit is complete and more data is queued.
                    // Start the next frame immediately.
                    load = 1'b1;
                end else begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        if (load) begin
            shift_next    = {fifo_mem[rd_ptr_reg], 1'b0};
            tx_next       = 1'b0;
            bit_cnt_next  = '0;
            baud_cnt_next = BAUD_RELOAD;
            state_next    = SEND;
        end
    end

    // Register the transmitter state. Reset abandons any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '1;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            tx_reg       <= 1'b1;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            tx_reg       <= tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed checks of uart_tx_fifo.
// The behavioural model tracks the FIFO as a queue and each frame by elapsed
// time. A UART monitor decodes the serial line independently.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int BAUD_A  = 16;
    localparam int BAUD_B  = 2604;
    localparam int DEPTH   = 4;
    localparam int FRAME_A = 10 * BAUD_A;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic       trmt_a, trmt_b;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_a, full_a, empty_a, busy_a, tx_done_a;
    logic       tx_b, full_b, empty_b, busy_b, tx_done_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.BAUD_DIV(BAUD_A), .DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst(rst_a), .trmt(trmt_a), .tx_data(tx_data_a),
        .TX(tx_a), .full(full_a), .empty(empty_a), .busy(busy_a), .tx_done(tx_done_a)
    );

    uart_tx_fifo #(.BAUD_DIV(BAUD_B), .DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst_b), .trmt(trmt_b), .tx_data(tx_data_b),
        .TX(tx_b), .full(full_b), .empty(empty_b), .busy(busy_b), .tx_done(tx_done_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of instance A ----------------
    logic [7:0] mq[$];       // bytes waiting in the FIFO
    logic [7:0] sent_q[$];   // bytes whose frames have started
    logic [7:0] rx_log[$];   // bytes decoded by the monitor
    bit         m_busy = 1'b0;
    int         m_t = 0;     // clock index within the current frame
    logic [7:0] m_byte = 8'h00;

    function automatic logic exp_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = m_t / BAUD_A;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit was_full;
        bit do_load;
        if (rst_a) begin
            mq.delete();
            sent_q.delete();
            m_busy = 1'b0;
            m_t = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            do_load = 1'b0;
            if (!m_busy) begin
                do_load = (mq.size() != 0);
            end else if (m_t == FRAME_A - 1) begin
                if (mq.size() != 0) do_load = 1'b1;
                else m_busy = 1'b0;
            end else begin
                m_t++;
            end
            if (do_load) begin
                m_byte = mq.pop_front();
                sent_q.push_back(m_byte);
                m_busy = 1'b1;
                m_t = 0;
            end
            if (trmt_a && !was_full) mq.push_back(tx_data_a);
        end
    end

    // Compare instance A against the model on every cycle.
    always @(negedge clk) begin
        if (rst_a) begin
            chk("a_rst_tx", tx_a, 1);
            chk("a_rst_busy", busy_a, 0);
            chk("a_rst_done", tx_done_a, 0);
            chk("a_rst_full", full_a, 0);
            chk("a_rst_empty", empty_a, 1);
        end else begin
            chk("a_tx", tx_a, exp_tx());
            chk("a_busy", busy_a, m_busy);
            chk("a_tx_done", tx_done_a, (m_busy && m_t == FRAME_A - 1));
            chk("a_full", full_a, (mq.size() == DEPTH));
            chk("a_empty", empty_a, (mq.size() == 0));
        end
    end

    // UART monitor: sample instance A's line at the middle of each bit.
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    always @(negedge clk) begin
        if (rst_a) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx_a == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt >= BAUD_A + BAUD_A/2 && mon_cnt <= 8*BAUD_A + BAUD_A/2
                && ((mon_cnt - BAUD_A/2) % BAUD_A) == 0)
                mon_byte[(mon_cnt - BAUD_A/2)/BAUD_A - 1] = tx_a;
            if (mon_cnt == 9*BAUD_A + BAUD_A/2) begin
                chk("rx_stop_bit", tx_a, 1);
                rx_log.push_back(mon_byte);
                chk("rx_has_loaded_byte", (sent_q.size() != 0), 1);
                if (sent_q.size() != 0) chk("rx_vs_loaded", mon_byte, sent_q.pop_front());
                mon_active = 1'b0;
            end
        end
    end

    int done_cnt_a = 0;
    int busy_cyc_a = 0;
    always @(negedge clk) begin
        if (tx_done_a) done_cnt_a++;
        if (busy_a) busy_cyc_a++;
    end

    // Caller sits just after a posedge; the push is sampled at the next edge.
    task automatic push_a(input logic [7:0] d);
        trmt_a = 1'b1;
        tx_data_a = d;
        @(posedge clk); #1;
        trmt_a = 1'b0;
    endtask

    task automatic wait_idle_a(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (!busy_a && empty_a) begin
                ok = 1'b1;
                break;
            end
        end
        chk("a_idle_timeout", ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int base_done;
        int base_busy;
        int pulses;
        int last_n;
        int hits;
        bit got;
        logic [9:0]  exp_frame_b;
        logic [7:0]  t5 [10];
        logic [7:0]  t3_bytes [5];
        rst_a = 1'b1; rst_b = 1'b1;
        trmt_a = 1'b0; trmt_b = 1'b0;
        tx_data_a = 8'h00; tx_data_b = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("b_rst_tx", tx_b, 1);
        chk("b_rst_busy", busy_b, 0);
        chk("b_rst_done", tx_done_b, 0);
        chk("b_rst_full", full_b, 0);
        chk("b_rst_empty", empty_b, 1);
        rst_a = 1'b0; rst_b = 1'b0;

        // Idle line for 1000 clocks.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (tx_b !== 1'b1 || busy_b !== 1'b0 || tx_done_b !== 1'b0) bad++;
        end
        chk("b_idle_violations", bad, 0);

        // Single 0xA5 frame at 2604 clocks per bit.
        exp_frame_b = 10'b1_10100101_0;
        tx_data_b = 8'hA5; trmt_b = 1'b1;
        @(posedge clk); #1;                     // E0: byte written
        trmt_b = 1'b0;
        chk("b_tx_after_write", tx_b, 1);
        chk("b_busy_after_write", busy_b, 0);
        chk("b_empty_after_write", empty_b, 0);
        @(posedge clk); #1;                     // E1: load, clock index 0
        chk("b_tx_after_load", tx_b, 0);
        chk("b_busy_after_load", busy_b, 1);
        chk("b_empty_after_load", empty_b, 1);
        pulses = 0; last_n = -1;
        for (int n = 1; n <= 10*BAUD_B + 2; n++) begin
            @(posedge clk); #1;
            if (tx_done_b) begin pulses++; last_n = n; end
            for (int k = 1; k < 10; k++) begin
                if (n == k*BAUD_B - 1) chk("b_bit_end", tx_b, exp_frame_b[k-1]);
                if (n == k*BAUD_B)     chk("b_bit_start", tx_b, exp_frame_b[k]);
            end
            if (n == 9*BAUD_B + BAUD_B/2) chk("b_stop_mid", tx_b, 1);
        end
        chk("b_done_pulses", pulses, 1);
        chk("b_done_clock", last_n, 10*BAUD_B - 1);
        chk("b_busy_end", busy_b, 0);
        chk("b_tx_end", tx_b, 1);

        // Burst of pushes into A: fills the FIFO, and the next push is dropped.
        rx_log.delete();
        base_done = done_cnt_a; base_busy = busy_cyc_a;
        push_a(8'h01); push_a(8'h80); push_a(8'hFF); push_a(8'h00);
        chk("t2_full_after_4", full_a, 0);      // the first byte was already loaded
        push_a(8'h22);
        chk("t2_full_after_5", full_a, 1);
        push_a(8'h55);
        chk("t2_full_after_drop", full_a, 1);
        wait_idle_a(2000);
        chk("t2_done_pulses", done_cnt_a - base_done, 5);
        chk("t2_busy_clocks", busy_cyc_a - base_busy, 5*FRAME_A);
        chk("t2_rx_count", rx_log.size(), 5);
        hits = 0;
        foreach (rx_log[i]) if (rx_log[i] == 8'h55) hits++;
        chk("t2_dropped_absent", hits, 0);

        // Push while full, in the same cycle as a load pop.
        rx_log.delete();
        t3_bytes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        foreach (t3_bytes[i]) push_a(t3_bytes[i]);
        chk("t3_full", full_a, 1);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (tx_done_a) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("t3_done_seen", got, 1);
        push_a(8'h77);                          // sampled at the load edge
        chk("t3_full_after_pop", full_a, 0);
        chk("t3_empty_after_pop", empty_a, 0);
        wait_idle_a(2000);
        chk("t3_rx_count", rx_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_log.size()) chk("t3_rx_byte", rx_log[i], t3_bytes[i]);
        end

        // Asynchronous reset in the middle of the fifth data bit.
        rx_log.delete();
        push_a(8'h3C);
        repeat (89) @(posedge clk);
        #3;
        chk("t4_busy_before_rst", busy_a, 1);
        rst_a = 1'b1;
        #1;
        chk("t4_rst_tx", tx_a, 1);
        chk("t4_rst_busy", busy_a, 0);
        chk("t4_rst_empty", empty_a, 1);
        chk("t4_rst_done", tx_done_a, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        base_done = done_cnt_a;
        repeat (400) @(posedge clk);
        #1;
        chk("t4_no_done", done_cnt_a - base_done, 0);
        chk("t4_no_rx", rx_log.size(), 0);
        chk("t4_tx_idle", tx_a, 1);

        // Ten spaced pushes that never hit full; the pointers wrap twice.
        rx_log.delete();
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(100, 220)) @(posedge clk);
            #1;
            got = 1'b0;
            for (int w = 0; w < 1000; w++) begin
                if (!full_a) begin got = 1'b1; break; end
                @(posedge clk); #1;
            end
            chk("t5_space_wait", got, 1);
            t5[i] = 8'($urandom);
            push_a(t5[i]);
        end
        wait_idle_a(2000);
        chk("t5_rx_count", rx_log.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < rx_log.size()) chk("t5_rx_byte", rx_log[i], t5[i]);
        end
        chk("t5_empty_end", empty_a, 1);

        // Random traffic, including pushes while full.
        for (int i = 0; i < 3000; i++) begin
            trmt_a = ($urandom_range(0, 5) == 0);
            tx_data_a = 8'($urandom);
            @(posedge clk); #1;
        end
        trmt_a = 1'b0;
        wait_idle_a(2000);
        chk("rand_sent_all", sent_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
